// File: rtl/systolic_feed_scheduler.sv
// Drives the diagonally skewed column-valid mask for one tile into the systolic
// array input stage, counts returned results and reports tile completion.
module systolic_feed_scheduler #(
  parameter int NUM_COLS = 16,
  parameter int LEN_W    = 8,
  parameter int STEP_W   = $clog2(2**LEN_W + NUM_COLS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [LEN_W-1:0]    i_len,
  input  logic                i_abort,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_start_err,
  output logic [NUM_COLS-1:0] o_valid,
  input  logic                i_ready,
  output logic [STEP_W-1:0]   o_step,
  input  logic                i_res_fire
);

  localparam int CW = STEP_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    k_q, k_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [NUM_COLS-1:0] valid_q, valid_d;
  logic [LEN_W:0]      res_cnt_q, res_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [STEP_W-1:0]   step_inc;
  logic [STEP_W-1:0]   t_last;
  logic [NUM_COLS-1:0] mask_inc;
  logic [LEN_W:0]      res_sum;
  logic                fire;
  logic                res_hit;
  logic                res_room;

  assign step_inc = step_q + STEP_W'(1);
  assign t_last   = STEP_W'(k_q) + STEP_W'(NUM_COLS - 2);
  assign fire     = (state_q == S_FEED) && (valid_q != '0) && i_ready;
  assign res_sum  = res_cnt_q + (LEN_W+1)'(i_res_fire);
  assign res_room = (res_cnt_q < {1'b0, k_q});
  assign res_hit  = (res_sum >= {1'b0, k_q});

  // Column c is live for steps c .. c+K-1; evaluated for the step we move to.
  generate
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_mask
      localparam logic [CW-1:0] COL = CW'(gi);
      assign mask_inc[gi] = ({1'b0, step_inc} >= COL) &&
                            ({1'b0, step_inc} < (COL + CW'(k_q)));
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    step_d    = step_q;
    valid_d   = valid_q;
    res_cnt_d = res_cnt_q;
    err_d     = 1'b0;

    if (i_abort) begin
      state_d   = S_IDLE;
      valid_d   = '0;
      step_d    = '0;
      res_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            if (i_len != '0) begin
              state_d   = S_FEED;
              k_d       = i_len;
              step_d    = '0;
              valid_d   = NUM_COLS'(1);
              res_cnt_d = '0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_FEED: begin
          err_d = i_start;
          if (i_res_fire && res_room) res_cnt_d = res_sum;
          if (fire) begin
            if (step_q == t_last) begin
              valid_d = '0;
              state_d = S_DRAIN;
            end else begin
              step_d  = step_inc;
              valid_d = mask_inc;
            end
          end
        end
        S_DRAIN: begin
          err_d = i_start;
          if (i_res_fire && res_room) res_cnt_d = res_sum;
          if (res_hit) state_d = S_DONE;
        end
        S_DONE: begin
          err_d   = i_start;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      step_q    <= '0;
      valid_q   <= '0;
      res_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      step_q    <= step_d;
      valid_q   <= valid_d;
      res_cnt_q <= res_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_start_err = err_q;
  assign o_valid     = valid_q;
  assign o_step      = step_q;

endmodule

// File: tb/tb_systolic_feed_scheduler.sv
// Scenario bench for systolic_feed_scheduler (4 columns): directed tiles from
// known mask tables plus randomized tiles checked against a mask/timing model.
module tb_systolic_feed_scheduler;

  localparam int NC = 4;
  localparam int LW = 5;
  localparam int SW = $clog2(2**LW + NC);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [LW-1:0] i_len = '0;
  logic          i_abort = 1'b0;
  logic          i_ready = 1'b0;
  logic          i_res_fire = 1'b0;
  logic          o_busy, o_done, o_start_err;
  logic [NC-1:0] o_valid;
  logic [SW-1:0] o_step;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  systolic_feed_scheduler #(.NUM_COLS(NC), .LEN_W(LW), .STEP_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_len(i_len),
    .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done),
    .o_start_err(o_start_err), .o_valid(o_valid), .i_ready(i_ready),
    .o_step(o_step), .i_res_fire(i_res_fire)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n = edge_n + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  // Mask for step t of a K-length tile: column c live when c <= t < c+K.
  function automatic logic [NC-1:0] ref_mask(input int t, input int k);
    logic [NC-1:0] m;
    for (int c = 0; c < NC; c++) m[c] = (c <= t) && (t < c + k);
    return m;
  endfunction

  task automatic start_tile(input int k);
    i_start = 1'b1;
    i_len   = LW'(k);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_busy, o_done, o_start_err, o_valid, o_step} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b valid=%b step=%0d want all zero",
               o_busy, o_done, o_start_err, o_valid, o_step);
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_basic();
    logic [NC-1:0] exp_m [6];
    exp_m = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    i_ready = 1'b1;
    start_tile(3);
    for (int t = 0; t < 6; t++) begin
      checks++;
      if (o_valid !== exp_m[t] || o_step !== SW'(t) || o_busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_feed t=%0d: got valid=%b step=%0d busy=%b want valid=%b step=%0d busy=1",
                 t, o_valid, o_step, o_busy, exp_m[t], t);
      end
      @(negedge clk);
    end
    checks++;
    if (o_valid !== 4'b0000 || o_busy !== 1'b1 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain_entry: got valid=%b busy=%b done=%b want 0000/1/0",
               o_valid, o_busy, o_done);
    end
    i_res_fire = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (o_done !== (i == 2)) begin
        errors++;
        $display("FAIL basic_done result=%0d: got done=%b want %b", i + 1, o_done, (i == 2));
      end
    end
    i_res_fire = 1'b0;
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_after_done: got done=%b busy=%b want 0/0", o_done, o_busy);
    end
    $display("test_basic done");
  endtask

  task automatic test_stall();
    logic [NC-1:0] exp_m [6];
    int t, stall, dut_fires, t2_cycles, cyc;
    exp_m = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    t = 0; stall = 0; dut_fires = 0; t2_cycles = 0; cyc = 0;
    i_ready = 1'b1;
    start_tile(3);
    while (t < 6 && cyc < 30) begin
      checks++;
      if (o_valid !== exp_m[t] || o_step !== SW'(t)) begin
        errors++;
        $display("FAIL stall_hold t=%0d: got valid=%b step=%0d want valid=%b step=%0d",
                 t, o_valid, o_step, exp_m[t], t);
      end
      if (o_step == SW'(2)) t2_cycles++;
      if (t == 2 && stall < 3) begin
        i_ready = 1'b0;
        stall++;
      end else begin
        i_ready = 1'b1;
      end
      if (o_valid != '0 && i_ready) dut_fires++;
      if (i_ready) t++;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (dut_fires !== 6 || t2_cycles !== 4 || o_valid !== 4'b0000) begin
      errors++;
      $display("FAIL stall_fires: got fires=%0d t2_cycles=%0d valid=%b want 6/4/0000",
               dut_fires, t2_cycles, o_valid);
    end
    i_ready = 1'b1;
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    $display("test_stall done");
  endtask

  task automatic test_k1_early_result();
    logic [NC-1:0] exp_m [4];
    exp_m = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    i_ready = 1'b1;
    start_tile(1);
    for (int t = 0; t < 4; t++) begin
      checks++;
      if (o_valid !== exp_m[t] || o_step !== SW'(t)) begin
        errors++;
        $display("FAIL k1_feed t=%0d: got valid=%b step=%0d want valid=%b step=%0d",
                 t, o_valid, o_step, exp_m[t], t);
      end
      i_res_fire = (t == 2);
      @(negedge clk);
    end
    i_res_fire = 1'b0;
    checks++;
    if (o_valid !== 4'b0000 || o_busy !== 1'b1 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL k1_drain: got valid=%b busy=%b done=%b want 0000/1/0", o_valid, o_busy, o_done);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL k1_done: got done=%b want 1", o_done);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL k1_idle: got done=%b busy=%b want 0/0", o_done, o_busy);
    end
    $display("test_k1_early_result done");
  endtask

  task automatic test_start_err();
    logic [NC-1:0] exp_m [6];
    exp_m = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    i_ready = 1'b1;
    start_tile(0);
    checks++;
    if (o_start_err !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_err: got err=%b busy=%b want 1/0", o_start_err, o_busy);
    end
    @(negedge clk);
    checks++;
    if (o_start_err !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_pulse: got err=%b busy=%b want 0/0", o_start_err, o_busy);
    end
    start_tile(3);
    @(negedge clk);
    start_tile(5);
    for (int t = 2; t < 6; t++) begin
      checks++;
      if (o_valid !== exp_m[t] || o_step !== SW'(t) || o_start_err !== (t == 2)) begin
        errors++;
        $display("FAIL midtile_start t=%0d: got valid=%b step=%0d err=%b want valid=%b step=%0d err=%b",
                 t, o_valid, o_step, o_start_err, exp_m[t], t, (t == 2));
      end
      @(negedge clk);
    end
    i_res_fire = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    i_res_fire = 1'b0;
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL midtile_done: got done=%b want 1", o_done);
    end
    @(negedge clk);
    $display("test_start_err done");
  endtask

  task automatic test_abort();
    logic [NC-1:0] exp_m [5];
    exp_m = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1000};
    i_ready = 1'b1;
    start_tile(3);
    for (int t = 0; t < 4; t++) begin
      i_abort = (t == 3);
      @(negedge clk);
    end
    i_abort = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_valid !== 4'b0000 || o_step !== '0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b valid=%b step=%0d done=%b want 0/0000/0/0",
               o_busy, o_valid, o_step, o_done);
    end
    i_res_fire = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done: got done=%b busy=%b want 0/0", o_done, o_busy);
      end
    end
    i_res_fire = 1'b0;
    start_tile(2);
    for (int t = 0; t < 5; t++) begin
      checks++;
      if (o_valid !== exp_m[t] || o_step !== SW'(t)) begin
        errors++;
        $display("FAIL abort_restart t=%0d: got valid=%b step=%0d want valid=%b step=%0d",
                 t, o_valid, o_step, exp_m[t], t);
      end
      @(negedge clk);
    end
    i_res_fire = 1'b1;
    repeat (2) @(negedge clk);
    i_res_fire = 1'b0;
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart_done: got done=%b want 1", o_done);
    end
    @(negedge clk);
    $display("test_abort done");
  endtask

  task automatic test_async_reset();
    i_ready = 1'b1;
    start_tile(2);
    repeat (5) @(negedge clk);
    i_res_fire = 1'b1;
    @(negedge clk);
    i_res_fire = 1'b0;
    checks++;
    if (o_busy !== 1'b1 || o_valid !== 4'b0000) begin
      errors++;
      $display("FAIL async_pre_drain: got busy=%b valid=%b want 1/0000", o_busy, o_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_done, o_start_err, o_valid, o_step} !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b err=%b valid=%b step=%0d want all zero",
               o_busy, o_done, o_start_err, o_valid, o_step);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_tile(1);
    checks++;
    if (o_valid !== 4'b0001 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL async_restart: got valid=%b busy=%b want 0001/1", o_valid, o_busy);
    end
    i_res_fire = 1'b1;
    @(negedge clk);
    i_res_fire = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (o_done !== 1'b1) begin
      errors++;
      $display("FAIL async_restart_done: got done=%b want 1", o_done);
    end
    @(negedge clk);
    $display("test_async_reset done");
  endtask

  // Model: fire index f selects the mask; done appears after edge max(F+1, R),
  // F = edge of the last fire, R = edge of the K-th counted result.
  task automatic test_random();
    int k, nf, f, sent, lf, lr, dn, cyc;
    for (int tile = 0; tile < 40; tile++) begin
      k = (tile == 0) ? 31 : int'($urandom_range(1, 12));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      checks++;
      if (o_busy !== 1'b0) begin
        errors++;
        $display("FAIL rand_idle tile=%0d: got busy=%b want 0", tile, o_busy);
      end
      start_tile(k);
      nf = k + NC - 1; f = 0; sent = 0; lf = -1; lr = -1; dn = -1; cyc = 0;
      forever begin
        checks++;
        if (dn >= 0 && edge_n == dn) begin
          if (o_done !== 1'b1 || o_valid !== '0) begin
            errors++;
            $display("FAIL rand_done tile=%0d k=%0d: got done=%b valid=%b want 1/0", tile, k, o_done, o_valid);
          end
          i_ready = 1'b0;
          i_res_fire = 1'b0;
          break;
        end
        if (o_done !== 1'b0 || o_busy !== 1'b1 ||
            (f < nf && (o_valid !== ref_mask(f, k) || o_step !== SW'(f))) ||
            (f >= nf && o_valid !== '0)) begin
          errors++;
          $display("FAIL rand_cycle tile=%0d k=%0d f=%0d: got done=%b busy=%b valid=%b step=%0d want 0/1/%b/%0d",
                   tile, k, f, o_done, o_busy, o_valid, o_step,
                   (f < nf) ? ref_mask(f, k) : 4'b0000, f);
        end
        i_ready = ($urandom_range(0, 3) != 0);
        if (f < nf && i_ready) begin
          f++;
          if (f == nf) lf = edge_n + 1;
        end
        if (sent < k) begin
          i_res_fire = ($urandom_range(0, 2) == 0);
          if (i_res_fire) begin
            sent++;
            if (sent == k) lr = edge_n + 1;
          end
        end else begin
          i_res_fire = (lf < 0) && ($urandom_range(0, 3) == 0);
        end
        if (lf >= 0 && lr >= 0) dn = (lf + 1 > lr) ? lf + 1 : lr;
        cyc++;
        if (cyc > 400) begin
          errors++;
          $display("FAIL rand_timeout tile=%0d: got no done within 400 cycles want done", tile);
          break;
        end
        @(negedge clk);
      end
      @(negedge clk);
      checks++;
      if (o_busy !== 1'b0 || o_done !== 1'b0) begin
        errors++;
        $display("FAIL rand_after tile=%0d: got busy=%b done=%b want 0/0", tile, o_busy, o_done);
      end
      $display("tile %0d k=%0d checked", tile, k);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_k1_early_result();
    test_start_err();
    test_abort();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
